// File: rtl/word_packer.sv
// Slot-indexed chunk packer: writes BUS_SIZE-bit chunks into slot k of a
// NUM_BLOCKS*BUS_SIZE word (slot 0 = LSBs) and hands the full word off over valid/ready.
module word_packer #(
   parameter int BITS_ENABLES = 2,
   parameter int BUS_SIZE     = 8,
   parameter int NUM_BLOCKS   = 2**BITS_ENABLES
) (
   input  logic                           i_clk,
   input  logic                           i_reset,
   input  logic                           i_valid,
   input  logic [BUS_SIZE-1:0]            i_data,
   output logic                           o_ready,
   input  logic                           i_flush,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [NUM_BLOCKS*BUS_SIZE-1:0] o_data,
   output logic [BITS_ENABLES-1:0]        o_slot
);

   localparam int WORD_W = NUM_BLOCKS * BUS_SIZE;
   localparam logic [BITS_ENABLES-1:0] SLOT_ZERO = BITS_ENABLES'(0);
   localparam logic [BITS_ENABLES-1:0] SLOT_ONE  = BITS_ENABLES'(1);
   localparam logic [BITS_ENABLES-1:0] SLOT_LAST = BITS_ENABLES'(NUM_BLOCKS - 1);

   typedef enum logic [0:0] {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } state_e;

   state_e                   state_q, state_d;
   logic [WORD_W-1:0]        data_q, data_d;
   logic [BITS_ENABLES-1:0]  slot_q, slot_d;
   logic                     ready;
   logic                     accept;

   // State register with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q <= ST_FILL;
         data_q  <= {WORD_W{1'b0}};
         slot_q  <= SLOT_ZERO;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         slot_q  <= slot_d;
      end
   end

   // Ready is combinational so a chunk can be taken in the same cycle the word leaves.
   always_comb begin
      ready  = i_reset & ((state_q != ST_FULL) | i_ready);
      accept = i_valid & ready & ~i_flush;
   end

   // Next-state logic; flush overrides both accept and handoff.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      slot_d  = slot_q;
      if (i_flush) begin
         state_d = ST_FILL;
         data_d  = {WORD_W{1'b0}};
         slot_d  = SLOT_ZERO;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (accept) begin
                  data_d[int'(slot_q)*BUS_SIZE +: BUS_SIZE] = i_data;
                  slot_d = slot_q + SLOT_ONE;
                  if (slot_q == SLOT_LAST) begin
                     state_d = ST_FULL;
                  end else begin
                     state_d = ST_FILL;
                  end
               end else begin
                  state_d = ST_FILL;
               end
            end
            ST_FULL: begin
               if (i_ready) begin
                  // Handoff: the next word starts from a cleared register.
                  state_d = ST_FILL;
                  data_d  = {WORD_W{1'b0}};
                  if (accept) begin
                     data_d[BUS_SIZE-1:0] = i_data;
                     slot_d = SLOT_ONE;
                  end else begin
                     slot_d = SLOT_ZERO;
                  end
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_FILL;
               data_d  = {WORD_W{1'b0}};
               slot_d  = SLOT_ZERO;
            end
         endcase
      end
   end

   // Output decode; everything but o_ready comes straight from flops.
   always_comb begin
      o_ready = ready;
      o_valid = (state_q == ST_FULL);
      o_data  = data_q;
      o_slot  = slot_q;
   end

endmodule

// File: tb/tb_word_packer.sv
// Directed self-checking bench for word_packer with BITS_ENABLES = 2, BUS_SIZE = 8.
module tb_word_packer;

   logic        i_clk;
   logic        i_reset;
   logic        i_valid;
   logic [7:0]  i_data;
   logic        o_ready;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic [1:0]  o_slot;

   int n_checks = 0;
   int n_fail   = 0;

   word_packer #(.BITS_ENABLES(2), .BUS_SIZE(8)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .i_flush (i_flush),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_slot  (o_slot)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      i_valid = 1'b1;
      i_data  = d;
      step();
      i_valid = 1'b0;
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      i_valid = 1'b1;
      i_data  = 8'hFF;
      step();
      step();
      n_checks++;
      if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 00000000", o_data); end
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
      n_checks++;
      if (o_slot !== 2'd0) begin n_fail++; $display("FAIL reset_slot: got %0d want 0", o_slot); end
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready); end
      i_valid = 1'b0;
      i_reset = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", o_ready); end
      step();
      n_checks++;
      if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_release_data: got %h want 00000000", o_data); end
   endtask

   task automatic test_fill_backpressure();
      logic [7:0] chunks [4];
      logic [1:0] slots  [4];
      chunks = '{8'h11, 8'h22, 8'h33, 8'h44};
      slots  = '{2'd1, 2'd2, 2'd3, 2'd0};
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(chunks[i]);
         n_checks++;
         if (o_slot !== slots[i]) begin n_fail++; $display("FAIL fill_slot[%0d]: got %0d want %0d", i, o_slot, slots[i]); end
      end
      n_checks++;
      if (o_data !== 32'h44332211) begin n_fail++; $display("FAIL fill_data: got %h want 44332211", o_data); end
      n_checks++;
      if (o_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %b want 1", o_valid); end
      i_valid = 1'b1;
      i_data  = 8'h55;
      #1;
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", o_ready); end
      step();
      n_checks++;
      if (o_data !== 32'h44332211) begin n_fail++; $display("FAIL full_hold_data: got %h want 44332211", o_data); end
      n_checks++;
      if (o_valid !== 1'b1 || o_slot !== 2'd0) begin n_fail++; $display("FAIL full_hold_state: got valid=%b slot=%0d want valid=1 slot=0", o_valid, o_slot); end
   endtask

   task automatic test_handoff_accept();
      i_valid = 1'b1;
      i_data  = 8'h55;
      i_ready = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL handoff_ready: got %b want 1", o_ready); end
      step();
      n_checks++;
      if (o_valid !== 1'b0) begin n_fail++; $display("FAIL handoff_valid: got %b want 0", o_valid); end
      n_checks++;
      if (o_data !== 32'h00000055) begin n_fail++; $display("FAIL handoff_data: got %h want 00000055", o_data); end
      n_checks++;
      if (o_slot !== 2'd1) begin n_fail++; $display("FAIL handoff_slot: got %0d want 1", o_slot); end
      i_valid = 1'b0;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
   endtask

   task automatic test_streaming();
      i_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         i_valid = 1'b1;
         i_data  = 8'(i);
         #1;
         n_checks++;
         if (o_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, o_ready); end
         step();
         if (i == 3) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h03020100) begin n_fail++; $display("FAIL stream_word0: got valid=%b data=%h want 1 03020100", o_valid, o_data); end
         end else if (i == 7) begin
            n_checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h07060504) begin n_fail++; $display("FAIL stream_word1: got valid=%b data=%h want 1 07060504", o_valid, o_data); end
         end else begin
            n_checks++;
            if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 0", i, o_valid); end
         end
      end
      i_valid = 1'b0;
      step();
      n_checks++;
      if (o_valid !== 1'b0 || o_data !== 32'h0 || o_slot !== 2'd0) begin n_fail++; $display("FAIL stream_drain: got valid=%b data=%h slot=%0d want 0 00000000 0", o_valid, o_data, o_slot); end
   endtask

   task automatic test_flush_partial();
      i_ready = 1'b0;
      send(8'hAA);
      send(8'hBB);
      n_checks++;
      if (o_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL partial_data: got %h want 0000BBAA", o_data); end
      i_valid = 1'b1;
      i_data  = 8'hCC;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      i_valid = 1'b0;
      n_checks++;
      if (o_data !== 32'h0 || o_slot !== 2'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_partial: got data=%h slot=%0d valid=%b want 00000000 0 0", o_data, o_slot, o_valid); end
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
      n_checks++;
      if (o_data !== 32'hA3A2A1A0 || o_valid !== 1'b1) begin n_fail++; $display("FAIL refill: got data=%h valid=%b want A3A2A1A0 1", o_data, o_valid); end
   endtask

   task automatic test_flush_full();
      i_ready = 1'b0;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      n_checks++;
      if (o_valid !== 1'b0 || o_data !== 32'h0 || o_slot !== 2'd0) begin n_fail++; $display("FAIL flush_full: got valid=%b data=%h slot=%0d want 0 00000000 0", o_valid, o_data, o_slot); end
   endtask

   task automatic test_reset_midword();
      i_ready = 1'b0;
      send(8'h01);
      send(8'h02);
      send(8'h03);
      n_checks++;
      if (o_data !== 32'h00030201 || o_slot !== 2'd3) begin n_fail++; $display("FAIL midword_data: got data=%h slot=%0d want 00030201 3", o_data, o_slot); end
      i_reset = 1'b0;
      i_valid = 1'b1;
      i_data  = 8'h77;
      i_flush = 1'b1;
      #1;
      n_checks++;
      if (o_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b want 0", o_ready); end
      step();
      n_checks++;
      if (o_data !== 32'h0 || o_slot !== 2'd0 || o_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got data=%h slot=%0d valid=%b want 00000000 0 0", o_data, o_slot, o_valid); end
      i_reset = 1'b1;
      i_valid = 1'b0;
      i_flush = 1'b0;
      #1;
      n_checks++;
      if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_release: got %b want 1", o_ready); end
   endtask

   initial begin
      i_reset = 1'b0;
      i_valid = 1'b0;
      i_data  = 8'h00;
      i_flush = 1'b0;
      i_ready = 1'b0;
      test_reset();
      test_fill_backpressure();
      test_handoff_accept();
      test_streaming();
      test_flush_partial();
      test_flush_full();
      test_reset_midword();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
